// File: rtl/channel_accumulate_unit_if.sv
// Product-beat input and pixel-result output bundle
// for the channel accumulate unit.
interface channel_accumulate_unit_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 9
);
  logic                        mul_valid;
  logic [SIZE-1:0][WIDTH-1:0]  din;
  logic                        out_valid;
  logic [WIDTH-1:0]            dout;

  modport master (
    output mul_valid,
    output din,
    input  out_valid,
    input  dout
  );

  modport slave (
    input  mul_valid,
    input  din,
    output out_valid,
    output dout
  );
endinterface

// File: rtl/channel_accumulate_unit.sv
// Registered adder-tree reduction of product beats,
// channel accumulation, bias add and optional ReLU.
module channel_accumulate_unit #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 9,
  parameter int CH_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_clear,
  channel_accumulate_unit_if.slave bus,
  input  logic [CH_W-1:0]  num_channels,
  input  logic [WIDTH-1:0] bias,
  input  logic             relu_en,
  output logic             busy
);

  localparam int D = (SIZE < 2) ? 1 : $clog2(SIZE);

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic int lvl_n(input int k);
    int n;
    n = SIZE;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] post(
    input logic [WIDTH-1:0] x,
    input logic             r
  );
    return (r && x[WIDTH-1]) ? '0 : x;
  endfunction

  // lv is double width so pair indexing never leaves range
  logic [WIDTH-1:0] lv [D+1][2*SIZE];
  logic [WIDTH-1:0] rg [D][SIZE];
  logic [WIDTH-1:0] nx [D][SIZE];
  logic [D-1:0]     vld;

  logic [WIDTH-1:0] tsum;
  logic             tvalid;

  always_comb begin
    for (int k = 0; k <= D; k++)
      for (int j = 0; j < 2*SIZE; j++)
        lv[k][j] = '0;
    for (int j = 0; j < SIZE; j++)
      lv[0][j] = bus.din[j];
    for (int k = 1; k <= D; k++)
      for (int j = 0; j < SIZE; j++)
        lv[k][j] = rg[k-1][j];
  end

  always_comb begin
    for (int k = 1; k <= D; k++)
      for (int j = 0; j < SIZE; j++) begin
        nx[k-1][j] = '0;
        if (j < lvl_n(k)) begin
          if (2*j+1 < lvl_n(k-1))
            nx[k-1][j] = lv[k-1][2*j]
                       + lv[k-1][2*j+1];
          else
            nx[k-1][j] = lv[k-1][2*j];
        end
      end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || soft_clear) begin
      vld <= '0;
      rg  <= '{default: '0};
    end else begin
      vld[0] <= bus.mul_valid;
      for (int k = 1; k < D; k++)
        vld[k] <= vld[k-1];
      rg <= nx;
    end
  end

  assign tsum   = rg[D-1][0];
  assign tvalid = vld[D-1];

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CH_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]  n_q, n_d;
  logic [WIDTH-1:0] bias_q, bias_d;
  logic             relu_q, relu_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ov_q, ov_d;
  logic [CH_W-1:0]  n_eff;
  logic             last;

  assign n_eff = (num_channels == '0)
               ? CH_W'(1) : num_channels;
  assign last  = (cnt_q == n_q - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n || soft_clear) state_q <= IDLE;
    else                      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (tvalid && n_eff != CH_W'(1))
          state_d = ACCUM;
      ACCUM:
        if (tvalid && last)
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    n_d    = n_q;
    bias_d = bias_q;
    relu_d = relu_q;
    dout_d = dout_q;
    ov_d   = 1'b0;
    unique case (state_q)
      IDLE:
        if (tvalid) begin
          if (n_eff == CH_W'(1)) begin
            dout_d = post(tsum + bias, relu_en);
            ov_d   = 1'b1;
          end else begin
            acc_d  = tsum;
            cnt_d  = CH_W'(1);
            n_d    = n_eff;
            bias_d = bias;
            relu_d = relu_en;
          end
        end
      ACCUM:
        if (tvalid) begin
          if (last) begin
            dout_d = post(acc_q + tsum + bias_q,
                          relu_q);
            ov_d   = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
          end else begin
            acc_d  = acc_q + tsum;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      default: ;
    endcase
  end

  // soft_clear keeps the last delivered pixel on dout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      n_q    <= CH_W'(1);
      bias_q <= '0;
      relu_q <= 1'b0;
      dout_q <= '0;
      ov_q   <= 1'b0;
    end else if (soft_clear) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ov_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      n_q    <= n_d;
      bias_q <= bias_d;
      relu_q <= relu_d;
      dout_q <= dout_d;
      ov_q   <= ov_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.dout      = dout_q;
  assign busy = (state_q == ACCUM) | (|vld);

endmodule

// File: doc/channel_accumulate_unit.md
Name: channel_accumulate_unit

Overview:
- Sits directly downstream of the Hadamard product stage in the convolution accelerator.
- Each cycle `mul_valid` is high, it reduces the SIZE element-wise products to one sum through a registered adder tree.
- It accumulates those sums over `num_channels` consecutive input channels, then adds a bias and optionally applies ReLU.
- Result: one output pixel per group, flagged by a single-cycle `out_valid`.

Parameters:
- WIDTH, 32, data width of each product, the accumulator and the output.
- SIZE, 9, number of products per beat (kernel window elements).
- CH_W, 8, width of the channel-count input.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- soft_clear  input  1  synchronous flush of pipeline and accumulator.
- mul_valid  input  1  din valid this cycle; no backpressure.
- din  input  [SIZE-1:0][WIDTH-1:0]  products from the Hadamard stage.
- num_channels  input  CH_W  channels per output pixel.
- bias  input  WIDTH  two's-complement bias added at group end.
- relu_en  input  1  clamp negative results to 0.
- out_valid  output  1  single-cycle pulse; dout valid.
- dout  output  WIDTH  accumulated result.
- busy  output  1  high while a group is partially accumulated or beats are in the tree.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All tree stage registers, valid shift chain, accumulator, channel counter, out_valid and dout are cleared to 0.
  - busy=0. FSM goes to IDLE.
  - Reset mid-group discards all partial data. No out_valid is produced for that group.
- Adder tree:
  - D = max(1, ceil(log2(SIZE))) register stages; D=4 for SIZE=9.
  - Stage k adds adjacent pairs from stage k-1. An odd leftover element passes through registered.
  - A valid bit travels alongside the data through each stage.
  - All additions are modulo 2^WIDTH (wrap, no saturation, no widening).
- Tree result `tsum` and `tvalid` appear D cycles after `mul_valid`.
- Channel count:
  - `N = num_channels`, with 0 treated as 1.
  - N, bias and relu_en are sampled on the tvalid that starts a group (channel counter = 0) and held for the whole group.
  - Changes to these inputs mid-group are ignored.
- FSM, IDLE:
  - On tvalid with N=1: `dout <= post(tsum + bias)`, out_valid=1 next cycle, stay IDLE.
  - On tvalid with N>1: `acc <= tsum`, `cnt <= 1`, go to ACCUM.
- FSM, ACCUM:
  - On tvalid with cnt < N-1: `acc <= acc + tsum`, `cnt++`.
  - On tvalid with cnt = N-1: `dout <= post(acc + tsum + bias)`, out_valid=1 next cycle, `acc <= 0`, `cnt <= 0`, go to IDLE.
  - No tvalid: hold state.
  - Gaps between beats are allowed and have no timeout.
- post(x): if relu_en and x[WIDTH-1]=1 then 0, else x.
- Latency: last mul_valid of a group at cycle t gives out_valid at t+D+1 (t+5 for SIZE=9).
- Back-to-back groups:
  - The final beat of group g and the first beat of group g+1 may be on consecutive cycles.
  - Throughput is one beat per cycle with no bubbles.
- dout holds its last value when out_valid=0.
- soft_clear:
  - Same effect as reset on the valid chain, acc, cnt and FSM.
  - dout is retained; out_valid forced to 0.
  - If soft_clear and mul_valid are high in the same cycle, clear wins and the beat is dropped.
  - If soft_clear and rst_n=0 coincide, the reset result applies.
- busy = (state==ACCUM) or any tree valid bit set.

Test Plan:
- N=1, bias=0, relu_en=0, din all 1 on one beat → out_valid exactly 5 cycles later, dout=9; busy drops the following cycle.
- N=3, bias=10, din all 2 then 3 then 4 on consecutive cycles → single out_valid 5 cycles after the third beat, dout=18+27+36+10=91; no intermediate pulses.
- N=2 groups back-to-back, 4 beats on consecutive cycles, din elements 1,1,2,2, bias=0 → dout=18 and dout=36 on two pulses 2 cycles apart.
- Wrap and ReLU:
  - din[0]=0xFFFF_FFFF, rest 0, N=1, bias=0, relu_en=0 → dout=0xFFFF_FFFF.
  - Same with relu_en=1 → dout=0.
  - din[0]=0xFFFF_FFFF, din[1]=2 → dout=1 (wrap).
- N=3, two beats sent, then soft_clear, then a fresh 3-beat group of all-1 inputs → only one out_valid, dout=27; no pulse for the aborted group.
- num_channels=0 with a single all-1 beat → behaves as N=1, dout=9.
- rst_n low for one cycle mid-group, then rst_n high → out_valid=0, busy=0, and the next complete group is correct.
